// File: rtl/bit_serial_subtractor_if.sv
// Valid/ready operand and result channel for the bit-serial subtractor.
// The master supplies operands and accepts results; the slave is the subtractor.
interface bit_serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             start;
  logic             ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             done;
  logic             res_ready;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             overflow;

  modport master (
    output start,
    output a,
    output b,
    output b_in,
    output res_ready,
    input  ready,
    input  done,
    input  diff,
    input  b_out,
    input  overflow
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  b_in,
    input  res_ready,
    output ready,
    output done,
    output diff,
    output b_out,
    output overflow
  );

endinterface

// File: rtl/bit_serial_subtractor.sv
// Serial a - b - b_in, one bit per clock LSB first, through one full-subtractor cell.
// Operands and results move over valid/ready handshakes; all outputs are registered.
module bit_serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bit_serial_subtractor_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             a_sign_q, a_sign_d;
  logic             b_sign_q, b_sign_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             bit_d;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    diff_d   = diff_q;
    b_out_d  = b_out_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    bit_d    = 1'b0;

    case (state_q)
      StIdle: begin
        done_d = 1'b0;
        if (bus.start) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          br_d     = bus.b_in;
          a_sign_d = bus.a[WIDTH-1];
          b_sign_d = bus.b[WIDTH-1];
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        bit_d  = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        br_d   = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
        res_d  = {bit_d, res_q[WIDTH-1:1]};
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          // bit_d is the result MSB produced on this final edge.
          diff_d  = res_d;
          b_out_d = br_d;
          ovf_d   = (a_sign_q != b_sign_q) && (bit_d != a_sign_q);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.res_ready) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        done_d  = 1'b0;
        state_d = StIdle;
      end
    endcase

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      diff_q   <= '0;
      b_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      diff_q   <= diff_d;
      b_out_q  <= b_out_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.diff     = diff_q;
  assign bus.b_out    = b_out_q;
  assign bus.overflow = ovf_q;

endmodule

// File: doc/bit_serial_subtractor.md
Name: bit_serial_subtractor

Overview:
Sequential N-bit subtractor computing diff = a - b - b_in, one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the ripple-carry four-bit adder in the arithmetic library. It trades latency for area. Operands enter and results leave through valid/ready handshakes, so it drops into the same datapath as the adder blocks.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  operand valid; request to begin a subtraction.
ready  output  1  high when the block can accept start (IDLE only).
a  input  WIDTH  minuend, sampled on the accepting edge.
b  input  WIDTH  subtrahend, sampled on the accepting edge.
b_in  input  1  borrow-in, sampled on the accepting edge.
done  output  1  result valid.
res_ready  input  1  consumer accepts the result.
diff  output  WIDTH  difference.
b_out  output  1  borrow-out; 1 means the unsigned result a < b + b_in.
overflow  output  1  two's-complement overflow of a - b - b_in.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state = IDLE; ready = 1.
  - done, diff, b_out, overflow, bit counter, borrow register and operand shift registers all = 0.
- States: IDLE, RUN, DONE.
- IDLE: ready = 1, done = 0.
  - On an edge with start = 1, the block loads:
    - a into shift register A;
    - b into shift register B;
    - b_in into borrow register br;
    - a[WIDTH-1] and b[WIDTH-1] into sign registers;
    - counter = 0.
  - Then IDLE -> RUN.
  - diff, b_out and overflow keep their previous values until the new result commits.
- RUN: ready = 0, done = 0. On each edge:
  - d = A[0] ^ B[0] ^ br
  - br <= (~A[0] & B[0]) | (~(A[0] ^ B[0]) & br)
  - result shift register <= {d, result[WIDTH-1:1]}
  - A and B shift right by one; counter increments.
- End of RUN: on the edge where counter == WIDTH-1, the block:
  - commits diff = final shifted result;
  - sets b_out = final br;
  - sets overflow = (a_sign != b_sign) && (diff[WIDTH-1] != a_sign);
  - moves RUN -> DONE.
- Latency: done is high exactly WIDTH clock edges after the edge that accepted start.
- DONE: done = 1, ready = 0.
  - diff, b_out and overflow are stable.
  - On an edge with res_ready = 1: DONE -> IDLE, done = 0. diff, b_out and overflow hold their values.
  - res_ready = 0 holds DONE indefinitely with stable outputs.
- start while RUN or DONE is ignored, and a, b and b_in are not re-sampled. Minimum spacing between accepts is WIDTH + 2 edges.
- res_ready outside DONE has no effect.
- Arithmetic:
  - The result is modulo 2^WIDTH; there is no saturation.
  - b_out is the unsigned borrow.
  - overflow uses only the original operand signs.
  - b_in participates in both diff and borrow, but overflow uses the sign rule above.
- Reset mid-operation (RUN or DONE): immediate return to the reset values above, and the in-flight result is discarded. The first start after reset release behaves normally.

Test Plan:
1. WIDTH=4, a=9, b=3, b_in=0, res_ready=1 -> done rises 4 edges after accept; diff=6, b_out=0, overflow=0; ready returns 1 one edge later.
2. a=3, b=9, b_in=0 -> diff=10 (4'hA), b_out=1, overflow=1 (3 - (-7) = 10 exceeds +7).
3. a=0, b=0, b_in=1 -> diff=15, b_out=1, overflow=0.
4. a=8, b=1, b_in=0 -> diff=7, b_out=0, overflow=1 (-8 - 1).
5. Backpressure: a=12, b=5, res_ready=0 for 6 cycles after done, with start pulsed and a/b/b_in toggled meanwhile -> done stays 1, diff=7 unchanged, ready=0; raising res_ready gives IDLE on the next edge, and a fresh start is then accepted.
6. Assert rst_n=0 two edges into RUN (a=9, b=3) -> done/diff/b_out/overflow=0 and ready=1 immediately; after release, a=5, b=5, b_in=0 -> diff=0, b_out=0, overflow=0, done after 4 edges.
